// File: rtl/fetcher.sv
// Instruction fetch stage: one AXI4-Lite read per accepted start pulse, with
// misaligned-PC and bus-error reporting so the core can trap instead of decoding.
module fetcher #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic [31:0]           pc,
  output logic [31:0]           instr_raw,
  output logic                  completed,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [31:0]           axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rvalid,
  output logic                  axi_rready
);

  localparam int unsigned DATA_W = 32;
  localparam logic [1:0]  RESP_OKAY = 2'b00;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_AR = 2'd1;
  localparam logic [1:0] WAIT_R  = 2'd2;
  localparam logic [1:0] FAULT   = 2'd3;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [ADDR_WIDTH-1:0] araddr_nxt;
  logic                  arvalid_nxt;
  logic                  rready_nxt;
  logic                  completed_nxt;
  logic                  error_nxt;
  logic [DATA_W-1:0]     instr_nxt;

  // Next-state and next-output logic; every output is then registered below.
  always_comb begin
    state_nxt     = state;
    araddr_nxt    = axi_araddr;
    arvalid_nxt   = axi_arvalid;
    rready_nxt    = axi_rready;
    completed_nxt = 1'b0;
    error_nxt     = error;
    instr_nxt     = instr_raw;

    case (state)
      IDLE: begin
        if (enable) begin
          if (pc[1:0] == 2'b00) begin
            araddr_nxt  = ADDR_WIDTH'(pc);
            arvalid_nxt = 1'b1;
            state_nxt   = WAIT_AR;
          end else begin
            state_nxt = FAULT;
          end
        end
      end
      WAIT_AR: begin
        if (axi_arvalid && axi_arready) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = WAIT_R;
        end
      end
      WAIT_R: begin
        if (axi_rvalid && axi_rready) begin
          rready_nxt    = 1'b0;
          completed_nxt = 1'b1;
          if (axi_rresp == RESP_OKAY) begin
            instr_nxt = axi_rdata;
            error_nxt = 1'b0;
          end else begin
            instr_nxt = NOP_INSTR;
            error_nxt = 1'b1;
          end
          state_nxt = IDLE;
        end
      end
      FAULT: begin
        completed_nxt = 1'b1;
        error_nxt     = 1'b1;
        instr_nxt     = NOP_INSTR;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset abandons any outstanding transaction; the slave is reset alongside.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      axi_araddr  <= '0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      completed   <= 1'b0;
      error       <= 1'b0;
      instr_raw   <= NOP_INSTR;
    end else begin
      state       <= state_nxt;
      axi_araddr  <= araddr_nxt;
      axi_arvalid <= arvalid_nxt;
      axi_rready  <= rready_nxt;
      completed   <= completed_nxt;
      error       <= error_nxt;
      instr_raw   <= instr_nxt;
    end
  end

endmodule

// File: tb/tb_fetcher.sv
// Directed bench for fetcher: a delay-configurable AXI4-Lite read slave plus
// per-scenario tasks with hand-computed expectations.
module tb_fetcher;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] instr_raw;
  logic        completed;
  logic        error;
  logic [31:0] axi_araddr;
  logic        axi_arvalid;
  logic        axi_arready = 1'b0;
  logic [31:0] axi_rdata = '0;
  logic [1:0]  axi_rresp = 2'b00;
  logic        axi_rvalid = 1'b0;
  logic        axi_rready;

  int checks = 0;
  int errors = 0;

  // Slave knobs
  int          ar_wait = 0;
  int          r_wait = 0;
  logic        fixed_en = 1'b0;
  logic [31:0] fixed_data = '0;
  logic [1:0]  fixed_resp = 2'b00;
  int          ar_cnt = 0;
  int          r_cnt = 0;
  logic [31:0] ar_cap = '0;

  fetcher dut (
    .clk(clk), .rstn(rstn), .enable(enable), .pc(pc),
    .instr_raw(instr_raw), .completed(completed), .error(error),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  // Slave reacts on the falling edge to the registered DUT outputs.
  always @(negedge clk) begin
    if (axi_arvalid === 1'b1) begin
      axi_arready = (ar_cnt >= ar_wait);
      if (axi_arready) ar_cap = axi_araddr;
      ar_cnt++;
    end else begin
      axi_arready = 1'b0;
      ar_cnt = 0;
    end
    if (axi_rready === 1'b1) begin
      axi_rvalid = (r_cnt >= r_wait);
      axi_rdata  = fixed_en ? fixed_data : mem(ar_cap);
      axi_rresp  = fixed_en ? fixed_resp : 2'b00;
      r_cnt++;
    end else begin
      axi_rvalid = 1'b0;
      r_cnt = 0;
    end
  end

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({axi_arvalid, axi_rready, completed, error} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got arvalid/rready/completed/error=%b expected 0000",
               {axi_arvalid, axi_rready, completed, error});
    end
    checks++;
    if (axi_araddr !== 32'h0) begin
      errors++; $display("FAIL reset_araddr: got %h expected 00000000", axi_araddr);
    end
    checks++;
    if (instr_raw !== NOP) begin
      errors++; $display("FAIL reset_instr: got %h expected %h", instr_raw, NOP);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_aligned();
    fixed_en = 1'b1; fixed_data = 32'h00A00093; fixed_resp = 2'b00;
    enable = 1'b1; pc = 32'h0000_0040;
    @(negedge clk);
    enable = 1'b0; pc = 32'hDEAD_BEE0;
    checks++;
    if (axi_arvalid !== 1'b1 || axi_araddr !== 32'h40 || completed !== 1'b0) begin
      errors++;
      $display("FAIL aligned_ar: got arvalid=%b araddr=%h completed=%b expected 1 00000040 0",
               axi_arvalid, axi_araddr, completed);
    end
    @(negedge clk);
    checks++;
    if (axi_arvalid !== 1'b0 || axi_rready !== 1'b1 || completed !== 1'b0) begin
      errors++;
      $display("FAIL aligned_r: got arvalid=%b rready=%b completed=%b expected 0 1 0",
               axi_arvalid, axi_rready, completed);
    end
    @(negedge clk);
    checks++;
    if (completed !== 1'b1 || instr_raw !== 32'h00A00093 || error !== 1'b0) begin
      errors++;
      $display("FAIL aligned_done: got completed=%b instr=%h error=%b expected 1 00a00093 0",
               completed, instr_raw, error);
    end
    @(negedge clk);
    checks++;
    if (completed !== 1'b0 || instr_raw !== 32'h00A00093) begin
      errors++;
      $display("FAIL aligned_hold: got completed=%b instr=%h expected 0 00a00093",
               completed, instr_raw);
    end
    fixed_en = 1'b0;
  endtask

  task automatic test_delayed();
    int n_ar = 0, n_r = 0, n_done = 0, n_unstable = 0;
    ar_wait = 4; r_wait = 3;
    fixed_en = 1'b1; fixed_data = 32'h1234_5678; fixed_resp = 2'b00;
    enable = 1'b1; pc = 32'h0000_0100;
    @(negedge clk);
    enable = 1'b0; pc = 32'h0000_0200;
    for (int i = 0; i < 20; i++) begin
      if (axi_arvalid === 1'b1) begin
        n_ar++;
        if (axi_araddr !== 32'h100) n_unstable++;
      end
      if (axi_rready === 1'b1) n_r++;
      if (completed === 1'b1) n_done++;
      @(negedge clk);
    end
    checks++;
    if (n_ar != 5) begin
      errors++; $display("FAIL delayed_arvalid_cycles: got %0d expected 5", n_ar);
    end
    checks++;
    if (n_unstable != 0) begin
      errors++; $display("FAIL delayed_araddr_stable: got %0d unstable cycles expected 0", n_unstable);
    end
    checks++;
    if (n_r != 4) begin
      errors++; $display("FAIL delayed_rready_cycles: got %0d expected 4", n_r);
    end
    checks++;
    if (n_done != 1 || instr_raw !== 32'h1234_5678 || error !== 1'b0) begin
      errors++;
      $display("FAIL delayed_done: got pulses=%0d instr=%h error=%b expected 1 12345678 0",
               n_done, instr_raw, error);
    end
    ar_wait = 0; r_wait = 0; fixed_en = 1'b0;
  endtask

  task automatic test_misaligned();
    int n_ar = 0;
    enable = 1'b1; pc = 32'h0000_0042;
    @(negedge clk);
    enable = 1'b0;
    if (axi_arvalid !== 1'b0) n_ar++;
    checks++;
    if (completed !== 1'b0) begin
      errors++; $display("FAIL misaligned_early: got completed=%b expected 0", completed);
    end
    @(negedge clk);
    if (axi_arvalid !== 1'b0) n_ar++;
    checks++;
    if (completed !== 1'b1 || error !== 1'b1 || instr_raw !== NOP) begin
      errors++;
      $display("FAIL misaligned_done: got completed=%b error=%b instr=%h expected 1 1 00000013",
               completed, error, instr_raw);
    end
    @(negedge clk);
    if (axi_arvalid !== 1'b0) n_ar++;
    checks++;
    if (n_ar != 0 || completed !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_no_bus: got arvalid_cycles=%0d completed=%b expected 0 0",
               n_ar, completed);
    end
  endtask

  task automatic test_rresp_error();
    fixed_en = 1'b1; fixed_data = 32'hFFFF_FFFF; fixed_resp = 2'b10;
    enable = 1'b1; pc = 32'h0000_0300;
    @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (completed !== 1'b1 || error !== 1'b1 || instr_raw !== NOP) begin
      errors++;
      $display("FAIL rresp_error: got completed=%b error=%b instr=%h expected 1 1 00000013",
               completed, error, instr_raw);
    end
    fixed_en = 1'b0; fixed_resp = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_ignore_and_reset();
    int n_done = 0, n_ar_extra = 0;
    r_wait = 3;
    enable = 1'b1; pc = 32'h0000_0080;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    // In WAIT_R now: this pulse must be dropped.
    enable = 1'b1; pc = 32'h0000_0100;
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (completed === 1'b1) n_done++;
      if (axi_arvalid === 1'b1) n_ar_extra++;
      @(negedge clk);
    end
    checks++;
    if (n_done != 1 || n_ar_extra != 0 || instr_raw !== mem(32'h80)) begin
      errors++;
      $display("FAIL ignore_enable: got pulses=%0d extra_ar=%0d instr=%h expected 1 0 %h",
               n_done, n_ar_extra, instr_raw, mem(32'h80));
    end
    r_wait = 0;
    ar_wait = 10;
    enable = 1'b1; pc = 32'h0000_00C0;
    @(negedge clk);
    enable = 1'b0;
    checks++;
    if (axi_arvalid !== 1'b1) begin
      errors++; $display("FAIL midreset_pre: got arvalid=%b expected 1", axi_arvalid);
    end
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    checks++;
    if (axi_arvalid !== 1'b0 || completed !== 1'b0 || instr_raw !== NOP ||
        error !== 1'b0 || axi_araddr !== 32'h0) begin
      errors++;
      $display("FAIL midreset_post: got arvalid=%b completed=%b instr=%h error=%b araddr=%h expected 0 0 00000013 0 00000000",
               axi_arvalid, completed, instr_raw, error, axi_araddr);
    end
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (completed === 1'b1 || axi_arvalid === 1'b1) n_done++;
      @(negedge clk);
    end
    checks++;
    if (n_done != 0) begin
      errors++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", n_done);
    end
    ar_wait = 0;
  endtask

  task automatic test_back_to_back();
    int n_window = 0, n_total;
    for (int i = 0; i < 10; i++) begin
      enable = 1'b1; pc = 32'h0000_0200 + 32'(4 * i);
      @(negedge clk);
      // Observation k = i+1; acceptances at k=0,3,6,9 (edges), completions at k=3,6,9.
      if ((i + 1) % 3 == 1) begin
        checks++;
        if (axi_arvalid !== 1'b1 || axi_araddr !== 32'h0000_0200 + 32'(4 * i)) begin
          errors++;
          $display("FAIL b2b_ar_k%0d: got arvalid=%b araddr=%h expected 1 %h",
                   i + 1, axi_arvalid, axi_araddr, 32'h0000_0200 + 32'(4 * i));
        end
      end
      if (completed === 1'b1) begin
        n_window++;
        checks++;
        if ((i + 1) % 3 != 0 || instr_raw !== mem(32'h0000_0200 + 32'(4 * (i - 2))) ||
            error !== 1'b0) begin
          errors++;
          $display("FAIL b2b_data_k%0d: got instr=%h error=%b expected %h 0",
                   i + 1, instr_raw, error, mem(32'h0000_0200 + 32'(4 * (i - 2))));
        end
      end
    end
    enable = 1'b0;
    checks++;
    if (n_window != 3) begin
      errors++; $display("FAIL b2b_window_count: got %0d expected 3", n_window);
    end
    n_total = n_window;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (completed === 1'b1) n_total++;
    end
    // The fourth acceptance (edge t+9) completes after the window.
    checks++;
    if (n_total != 4 || instr_raw !== mem(32'h0000_0224)) begin
      errors++;
      $display("FAIL b2b_total: got pulses=%0d instr=%h expected 4 %h",
               n_total, instr_raw, mem(32'h0000_0224));
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_delayed();
    test_misaligned();
    test_rresp_error();
    test_ignore_and_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
